load_writeback_unit: RTL
========================

Name: load_writeback_unit

Overview:
- Write-port driver for the RV32I register file. It is the producer of write_reg / write_data / write_enable.
- Accepts writeback requests from the execute stage. ALU results are written directly.
- Loads are fetched from data memory through a valid/ready request and response interface. The unit then byte-, half- or word-extracts the data and sign- or zero-extends it before writing.
- Only one load is outstanding at a time. The upstream stage stalls on req_ready low.

Parameters:
- XLEN, 32, data width; matches the register file word width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  writeback request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_is_load  input  1  1 = load (memory access), 0 = ALU result.
- req_rd  input  5  destination register.
- req_data  input  XLEN  ALU result if ALU request, byte address if load.
- req_funct3  input  3  load width/sign code; ignored for ALU requests.
- mem_req_valid  output  1  memory read request.
- mem_req_ready  input  1  memory accepts request.
- mem_addr  output  XLEN  word-aligned address (req_data with bits [1:0] forced to 0).
- mem_rsp_valid  input  1  read data valid.
- mem_rdata  input  XLEN  read word.
- write_reg  output  5  register file write address.
- write_data  output  XLEN  register file write data.
- write_enable  output  1  one-cycle write strobe.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high): state IDLE.
  - All outputs 0 except req_ready, which is 1.
  - Any outstanding memory transaction is abandoned.
  - An mem_rsp_valid arriving later while in IDLE is ignored.
- All outputs are registered. req_ready = (state == IDLE).
- States and transitions:
  - IDLE, ALU request accepted (req_valid & ~req_is_load): next cycle write_reg = req_rd, write_data = req_data, write_enable = 1. The state stays IDLE, so back-to-back ALU requests write on consecutive cycles (1-cycle latency, full throughput).
  - IDLE, load accepted: capture rd, funct3 and addr[1:0]. Go to MEM_REQ; mem_req_valid = 1 with mem_addr from the next cycle.
  - MEM_REQ: hold mem_req_valid and mem_addr stable until mem_req_ready = 1. That handshake cycle moves the unit to MEM_WAIT and drops mem_req_valid.
  - MEM_WAIT: wait for mem_rsp_valid. mem_rsp_valid is sampled only in this state, so the earliest response is the cycle after the request handshake. On mem_rsp_valid, the write strobe is driven the next cycle and the state returns to IDLE.
  - A request presented during the write-strobe cycle is accepted (req_ready is 1 then).
- Minimum load latency: 3 cycles from acceptance to write_enable, with zero-wait memory.
- Extraction, using the captured addr[1:0]:
  - funct3 000 LB: sign-extend byte mem_rdata[8*a +: 8].
  - funct3 001 LH: sign-extend half mem_rdata[16*a[1] +: 16].
  - funct3 010 LW: full word.
  - funct3 100 LBU: zero-extend the selected byte.
  - funct3 101 LHU: zero-extend the selected half.
  - funct3 011, 110, 111: treated as LW.
- rd == 0: the request is processed normally, including the memory access, but write_enable stays 0. write_reg and write_data still update.
- write_enable is high for exactly one cycle per accepted non-x0 request. It is 0 at all other times.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A load with LH/LHU and addr[0] = 1, or LW and addr[1:0] != 0, issues no memory request and performs no register write.
  - misalign_err pulses 1 for one cycle, the cycle after acceptance. The unit stays in IDLE.
- When undefined:
  - No port is added.
  - Misaligned halves use a[1] only; misaligned words ignore addr[1:0].

Test Plan:
- ALU burst: requests rd=5 data 0x11, rd=6 data 0x22 on consecutive cycles -> write_enable high for 2 consecutive cycles, writing (5, 0x11) then (6, 0x22); req_ready stays 1.
- Sign-extended byte: LB at addr 0x103 (funct3 000), rdata 0x80FF_0000 -> write_data 0xFFFF_FF80.
- Zero-extended half: LHU at addr 0x102 (funct3 101), rdata 0xBEEF_1234 -> write_data 0x0000_BEEF.
- Memory backpressure: LW at 0x200 with mem_req_ready low for 3 cycles then high, then response 2 cycles later with 0xDEADBEEF:
  - mem_addr and mem_req_valid stay stable throughout the wait.
  - req_ready stays 0 until the write cycle.
  - A single write of 0xDEADBEEF.
- x0 target: LW with rd=0 -> memory handshake occurs, write_enable never asserts.
- Reset mid-load: assert reset while in MEM_WAIT, then drive mem_rsp_valid after reset deasserts -> outputs 0, req_ready 1, no write occurs. With LOAD_MISALIGN_TRAP_EN, an LW at 0x201 -> misalign_err pulses once, with no mem_req_valid and no write.

Source files
------------

// File: rtl/load_writeback_unit.sv
// Register-file write-port driver: direct ALU writeback plus single-outstanding loads
// with byte/half/word extraction. Optional macro: LOAD_MISALIGN_TRAP_EN.
module load_writeback_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_load,
    input  logic [4:0]      req_rd,
    input  logic [XLEN-1:0] req_data,
    input  logic [2:0]      req_funct3,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    output logic            write_enable,
`ifdef LOAD_MISALIGN_TRAP_EN
    output logic            misalign_err,
`endif
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [4:0]      rd_q, rd_next;
    logic [2:0]      funct3_q, funct3_next;
    logic [1:0]      offset_q, offset_next;
    logic [XLEN-1:0] mem_addr_next;
    logic [4:0]      write_reg_next;
    logic [XLEN-1:0] write_data_next;
    logic            write_enable_next;
    logic            misalign_next;
    logic            misaligned;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                                input logic [2:0]      f3,
                                                input logic [1:0]      a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extract = {{(XLEN-8){b[7]}}, b};
            3'b001:  extract = {{(XLEN-16){h[15]}}, h};
            3'b100:  extract = {{(XLEN-8){1'b0}}, b};
            3'b101:  extract = {{(XLEN-16){1'b0}}, h};
            default: extract = word;
        endcase
    endfunction

`ifdef LOAD_MISALIGN_TRAP_EN
    // Reserved funct3 codes behave as word loads, so they trap like LW.
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = req_data[0];
            default:        misaligned = (req_data[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next        = state;
        rd_next           = rd_q;
        funct3_next       = funct3_q;
        offset_next       = offset_q;
        mem_addr_next     = mem_addr;
        write_reg_next    = write_reg;
        write_data_next   = write_data;
        write_enable_next = 1'b0;
        misalign_next     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!req_is_load) begin
                        write_reg_next    = req_rd;
                        write_data_next   = req_data;
                        write_enable_next = (req_rd != 5'd0);
                    end else if (misaligned) begin
                        misalign_next = 1'b1;
                    end else begin
                        rd_next       = req_rd;
                        funct3_next   = req_funct3;
                        offset_next   = req_data[1:0];
                        mem_addr_next = {req_data[XLEN-1:2], 2'b00};
                        state_next    = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                if (mem_req_ready)
                    state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    write_reg_next    = rd_q;
                    write_data_next   = extract(mem_rdata, funct3_q, offset_q);
                    write_enable_next = (rd_q != 5'd0);
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            rd_q          <= 5'd0;
            funct3_q      <= 3'd0;
            offset_q      <= 2'd0;
            mem_addr      <= '0;
            write_reg     <= 5'd0;
            write_data    <= '0;
            write_enable  <= 1'b0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
            misalign_err  <= 1'b0;
`endif
        end else begin
            state         <= state_next;
            rd_q          <= rd_next;
            funct3_q      <= funct3_next;
            offset_q      <= offset_next;
            mem_addr      <= mem_addr_next;
            write_reg     <= write_reg_next;
            write_data    <= write_data_next;
            write_enable  <= write_enable_next;
            req_ready     <= (state_next == IDLE);
            busy          <= (state_next != IDLE);
            mem_req_valid <= (state_next == MEM_REQ);
`ifdef LOAD_MISALIGN_TRAP_EN
            misalign_err  <= misalign_next;
`endif
        end
    end

`ifndef LOAD_MISALIGN_TRAP_EN
    logic unused_misalign;
    assign unused_misalign = misalign_next;
`endif

endmodule
